// File: rtl/gf_tower_pkg.sv
// GF(2^6) arithmetic in the tower GF((2^3)^2): base field GF(8) mod z^3+z+1,
// extension w^2 + w + lambda with lambda = z^2+1, polynomial-basis side mod x^6+x+1.
package gf_tower_pkg;

    localparam int FIELD_W = 6;
    localparam int BASE_W  = 3;

    typedef logic [FIELD_W-1:0] gf64_t;
    typedef logic [BASE_W-1:0]  gf8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tower elements are stored as {a, b} meaning a + (a*z^2 + b)*w, so unity is {1, z^2}.
    localparam gf64_t ONE_T      = 6'h0C;
    localparam gf8_t  GF8_LAMBDA = 3'b101;
    localparam gf8_t  GF8_Z2     = 3'b100;

    function automatic gf8_t gf8_mul(input gf8_t a, input gf8_t b);
        logic [4:0] p;
        p[0] = a[0] & b[0];
        p[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
        p[2] = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
        p[3] = (a[1] & b[2]) ^ (a[2] & b[1]);
        p[4] = a[2] & b[2];
        return {p[2] ^ p[4], p[1] ^ p[3] ^ p[4], p[0] ^ p[3]};
    endfunction

    function automatic gf8_t gf8_const_mul(input gf8_t a);
        return gf8_mul(a, GF8_LAMBDA);
    endfunction

    function automatic gf8_t gf8_sq(input gf8_t a);
        return {a[1] ^ a[2], a[2], a[0]};
    endfunction

    // Coefficient of w and constant term of a stored tower element.
    function automatic gf8_t tw_hi(input gf64_t t);
        return gf8_mul(t[5:3], GF8_Z2) ^ t[2:0];
    endfunction

    function automatic gf8_t tw_lo(input gf64_t t);
        return t[5:3];
    endfunction

    function automatic gf64_t tw_pack(input gf8_t h, input gf8_t l);
        return {l, h ^ gf8_mul(l, GF8_Z2)};
    endfunction

    function automatic gf64_t gf64_sq(input gf64_t t);
        gf8_t h2;
        h2 = gf8_sq(tw_hi(t));
        return tw_pack(h2, gf8_const_mul(h2) ^ gf8_sq(tw_lo(t)));
    endfunction

    // Column images of the polynomial basis 1, x, ..., x^5.
    function automatic gf64_t iso(input gf64_t x);
        return ({FIELD_W{x[0]}} & 6'h0C) ^ ({FIELD_W{x[1]}} & 6'h37) ^
               ({FIELD_W{x[2]}} & 6'h04) ^ ({FIELD_W{x[3]}} & 6'h20) ^
               ({FIELD_W{x[4]}} & 6'h19) ^ ({FIELD_W{x[5]}} & 6'h3A);
    endfunction

    function automatic gf64_t inv_iso(input gf64_t t);
        return ({FIELD_W{t[0]}} & 6'h23) ^ ({FIELD_W{t[1]}} & 6'h1B) ^
               ({FIELD_W{t[2]}} & 6'h04) ^ ({FIELD_W{t[3]}} & 6'h05) ^
               ({FIELD_W{t[4]}} & 6'h36) ^ ({FIELD_W{t[5]}} & 6'h08);
    endfunction

endpackage

// File: rtl/gf64_tower_mul.sv
// Combinational GF((2^3)^2) multiplier using three GF(8) products (Karatsuba form).
module gf64_tower_mul
    import gf_tower_pkg::*;
(
    input  logic [FIELD_W-1:0] a,
    input  logic [FIELD_W-1:0] b,
    output logic [FIELD_W-1:0] p
);

    gf8_t ah, al, bh, bl;
    gf8_t hh, ll, mm;

    always_comb begin
        ah = tw_hi(a);
        al = tw_lo(a);
        bh = tw_hi(b);
        bl = tw_lo(b);
        hh = gf8_mul(ah, bh);
        ll = gf8_mul(al, bl);
        mm = gf8_mul(ah ^ al, bh ^ bl);
        // w^2 = w + lambda folds the high product into both halves.
        p  = tw_pack(mm ^ ll, gf8_const_mul(hh) ^ ll);
    end

endmodule

// File: rtl/sms_pow_engine.sv
// Multi-lane y = x^e over GF(2^6) by left-to-right square-and-multiply in the tower field,
// one exponent bit per cycle, with valid/ready handshakes on input and output.
module sms_pow_engine
    import gf_tower_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int EXP_W   = 6,
    parameter int FIELD_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*FIELD_W-1:0] in_x,
    input  logic [EXP_W-1:0]         in_exp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*FIELD_W-1:0] out_y,
    output logic                     busy
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t                   state_q, state_d;
    logic [EXP_W-1:0]         exp_q, exp_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    gf64_t                    acc_q [LANES];
    gf64_t                    acc_d [LANES];
    gf64_t                    base_q[LANES];
    gf64_t                    base_d[LANES];
    gf64_t                    sq_w  [LANES];
    gf64_t                    prod_w[LANES];
    gf64_t                    step_w[LANES];
    logic [LANES*FIELD_W-1:0] out_y_q, out_y_d;
    logic                     exp_bit;

    assign exp_bit = exp_q[cnt_q];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign sq_w[g] = gf64_sq(acc_q[g]);

        gf64_tower_mul u_mul (
            .a(sq_w[g]),
            .b(base_q[g]),
            .p(prod_w[g])
        );

        assign step_w[g] = exp_bit ? prod_w[g] : sq_w[g];
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        out_y_d = out_y_q;
        acc_d   = acc_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        base_d[l] = iso(in_x[l*FIELD_W +: FIELD_W]);
                        acc_d[l]  = ONE_T;
                    end
                    exp_d   = in_exp;
                    cnt_d   = CNT_W'(EXP_W - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l] = step_w[l];
                end
                if (cnt_q == '0) begin
                    for (int l = 0; l < LANES; l++) begin
                        out_y_d[l*FIELD_W +: FIELD_W] = inv_iso(step_w[l]);
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            cnt_q   <= '0;
            out_y_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l]  <= '0;
                base_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            out_y_q <= out_y_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l]  <= acc_d[l];
                base_q[l] <= base_d[l];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_y     = out_y_q;

endmodule

// File: tb/tb_sms_pow_engine.sv
// Scoreboard bench for sms_pow_engine (4 lanes): reference is plain GF(2^6) arithmetic mod x^6+x+1.
module tb_sms_pow_engine;

    localparam int L  = 4;
    localparam int EW = 6;
    localparam int W  = L * 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_y;
    logic          busy;

    sms_pow_engine #(.LANES(L), .EXP_W(EW), .FIELD_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] x;
        logic [5:0]   e;
        logic [W-1:0] y;
        int           acc_cyc;
    } txn_t;

    txn_t         sb[$];
    logic [W-1:0] recv[$];
    int           checks = 0;
    int           errors = 0;
    bit           mon_done = 1'b0;
    bit           rnd_done = 1'b0;

    function automatic logic [5:0] pmul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r  = '0;
        logic [5:0] aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
        end
        return r;
    endfunction

    function automatic logic [5:0] ppow(input logic [5:0] x, input logic [5:0] e);
        logic [5:0] y = 6'h01;
        for (int k = 0; k < int'(e); k++) y = pmul(y, x);
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [5:0] e);
        txn_t t;
        int   n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_x     = x;
        in_exp   = e;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_x     = W'($urandom);
            in_exp   = EW'($urandom);
            t.x       = x;
            t.e       = e;
            t.acc_cyc = cyc;
            for (int i = 0; i < L; i++) t.y[6*i +: 6] = ppow(x[6*i +: 6], e);
            sb.push_back(t);
        end
    endtask

    task automatic monitor();
        txn_t       t;
        logic       prev = 1'b0;
        logic [5:0] xi, yi;
        while (!mon_done) begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev && sb.size() > 0)
                    chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(EW));
                if (out_valid && !out_ready && sb.size() > 0)
                    chk("hold_out_y", 32'(out_y), 32'(sb[0].y));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%0h required=none", out_y);
                    end else begin
                        t = sb.pop_front();
                        chk("out_y", 32'(out_y), 32'(t.y));
                        for (int i = 0; i < L; i++) begin
                            xi = t.x[6*i +: 6];
                            yi = out_y[6*i +: 6];
                            if (t.e == 6'd1)
                                chk("e1_identity", 32'(yi), 32'(xi));
                            else if (t.e == 6'd62)
                                chk("e62_inverse", (xi == 0) ? 32'(yi) : 32'(pmul(xi, yi)),
                                    (xi == 0) ? 32'd0 : 32'd1);
                            else if (t.e == 6'd63)
                                chk("e63_unit", 32'(yi), (xi != 0) ? 32'd1 : 32'd0);
                        end
                        recv.push_back(out_y);
                    end
                end
                prev = out_valid;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           n;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
                $fatal(1);
            end
        join_none

        // Reset state, during and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_y", 32'(out_y), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed corner values
        send({6'h2A, 6'h00, 6'h01, 6'h00}, 6'd0);
        send({6'h2A, 6'h3F, 6'h00, 6'h01}, 6'd5);
        send({6'h3F, 6'h2A, 6'h01, 6'h00}, 6'd2);

        // Full-field sweeps for the exponents with known closed forms
        foreach (sweep_e[j]) begin
            for (int k = 0; k < 16; k++)
                send({6'(4*k+3), 6'(4*k+2), 6'(4*k+1), 6'(4*k)}, sweep_e[j]);
        end
        drain();

        // Squaring is additive
        recv.delete();
        a = W'($urandom);
        b = W'($urandom);
        send(a, 6'd2);
        send(b, 6'd2);
        send(a ^ b, 6'd2);
        drain();
        if (recv.size() == 3)
            chk("additivity", 32'(recv[0] ^ recv[1]), 32'(recv[2]));
        else
            chk("additivity_count", 32'(recv.size()), 32'd3);

        // Backpressure: result held, input side closed, stray in_valid ignored
        @(posedge clk); #1 out_ready = 1'b0;
        send(W'($urandom), 6'($urandom_range(1, 63)));
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_x     = W'($urandom);
            in_exp   = EW'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) send(W'($urandom), 6'($urandom));
        drain();

        // Reset in the middle of RUN discards the operation
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_x     = W'($urandom);
        in_exp   = 6'h3F;
        @(negedge clk);
        chk("abort_pre_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_y", 32'(out_y), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        chk("abort_idle", 32'(in_ready), 32'd1);

        // Random operands and exponents under random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) send(W'($urandom), 6'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        mon_done = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic [5:0] sweep_e [4] = '{6'd1, 6'd5, 6'd62, 6'd63};

endmodule
